// File: rtl/roulette_pkg.sv
// Shared definitions for the roulette bet ledger: opcode defaults, the
// round-state encoding and the slot entry width helper.
package roulette_pkg;

  localparam logic [5:0] SPIN_CODE_DEF  = 6'b111110;
  localparam logic [5:0] CLEAR_CODE_DEF = 6'b111111;
  localparam int         NO_CHIP        = 0;

  typedef enum logic [1:0] {
    OPEN,
    SPIN,
    PAYOUT
  } round_state_t;

  // A slot entry is {chip_color, bet_opcode}.
  function automatic int entry_w(input int chip_w, input int opcode_w);
    return chip_w + opcode_w;
  endfunction

endpackage

// File: rtl/bet_ledger_if.sv
// Keyboard/round handshake and flattened slot bus between the ledger and its
// surroundings (keyboard decoder, wheel controller, payout processor).
interface bet_ledger_if #(
  parameter int NUM_SLOTS = 12,
  parameter int OPCODE_W  = 6,
  parameter int CHIP_W    = 3
);
  localparam int ENTRY_W = roulette_pkg::entry_w(CHIP_W, OPCODE_W);
  localparam int CNT_W   = $clog2(NUM_SLOTS + 1);

  logic                         key_strobe;
  logic [OPCODE_W-1:0]          key_opcode;
  logic [CHIP_W-1:0]            chip_color;
  logic                         spin_ack;
  logic                         payout_done;
  logic [NUM_SLOTS*ENTRY_W-1:0] bets_flat;
  logic [NUM_SLOTS-1:0]         valid_mask;
  logic [CNT_W-1:0]             bet_count;
  logic                         full;
  logic                         spin_req;
  logic                         locked;
  logic                         accept_pulse;
  logic                         reject_pulse;

  modport master (
    output key_strobe, key_opcode, chip_color, spin_ack, payout_done,
    input  bets_flat, valid_mask, bet_count, full, spin_req, locked,
           accept_pulse, reject_pulse
  );

  modport slave (
    input  key_strobe, key_opcode, chip_color, spin_ack, payout_done,
    output bets_flat, valid_mask, bet_count, full, spin_req, locked,
           accept_pulse, reject_pulse
  );
endinterface

// File: rtl/bet_slot_lookup.sv
// Combinational slot search: which valid slots already hold the key opcode,
// and the lowest-index free slot.
module bet_slot_lookup #(
  parameter int NUM_SLOTS = 12,
  parameter int OPCODE_W  = 6,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0][OPCODE_W-1:0] slot_ops,
  input  logic [NUM_SLOTS-1:0]               slot_valid,
  input  logic [OPCODE_W-1:0]                key_opcode,
  output logic [NUM_SLOTS-1:0]               match_vec,
  output logic [IDX_W-1:0]                   hit_idx,
  output logic [IDX_W-1:0]                   free_idx,
  output logic                               any_free
);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
    assign match_vec[gi] = slot_valid[gi] && (slot_ops[gi] == key_opcode);
  end

  // Scanning downward lets the lowest index win; opcodes are unique so at
  // most one match bit is ever set anyway.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (match_vec[i])   hit_idx  = IDX_W'(i);
      if (!slot_valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_free = ~&slot_valid;

endmodule

// File: rtl/bet_ledger.sv
// Bet ledger: single-event keystroke capture, repeat-bet merging and the
// OPEN/SPIN/PAYOUT round sequence over NUM_SLOTS {colour, opcode} slots.
module bet_ledger
  import roulette_pkg::*;
#(
  parameter int                  NUM_SLOTS  = 12,
  parameter int                  OPCODE_W   = 6,
  parameter int                  CHIP_W     = 3,
  parameter logic [OPCODE_W-1:0] SPIN_CODE  = SPIN_CODE_DEF,
  parameter logic [OPCODE_W-1:0] CLEAR_CODE = CLEAR_CODE_DEF
) (
  input logic          clock,
  input logic          reset,
  bet_ledger_if.slave  bus
);
  localparam int ENTRY_W = entry_w(CHIP_W, OPCODE_W);
  localparam int CNT_W   = $clog2(NUM_SLOTS + 1);
  localparam int IDX_W   = $clog2(NUM_SLOTS);

  round_state_t                       state_reg, state_next;
  logic [NUM_SLOTS-1:0][OPCODE_W-1:0] op_reg, op_next;
  logic [NUM_SLOTS-1:0][CHIP_W-1:0]   col_reg, col_next;
  logic [NUM_SLOTS-1:0]               valid_reg, valid_next;
  logic [CNT_W-1:0]                   count_reg, count_next;
  logic                               strobe_prev_reg;
  logic                               accept_reg, accept_next;
  logic                               reject_reg, reject_next;

  logic                 key_event;
  logic [NUM_SLOTS-1:0] match_vec;
  logic [IDX_W-1:0]     hit_idx, free_idx;
  logic                 any_free;

  assign key_event = bus.key_strobe && !strobe_prev_reg;

  bet_slot_lookup #(
    .NUM_SLOTS(NUM_SLOTS),
    .OPCODE_W (OPCODE_W),
    .IDX_W    (IDX_W)
  ) u_lookup (
    .slot_ops  (op_reg),
    .slot_valid(valid_reg),
    .key_opcode(bus.key_opcode),
    .match_vec (match_vec),
    .hit_idx   (hit_idx),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= OPEN;
      op_reg          <= '0;
      col_reg         <= '0;
      valid_reg       <= '0;
      count_reg       <= '0;
      strobe_prev_reg <= 1'b0;
      accept_reg      <= 1'b0;
      reject_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      col_reg         <= col_next;
      valid_reg       <= valid_next;
      count_reg       <= count_next;
      strobe_prev_reg <= bus.key_strobe;
      accept_reg      <= accept_next;
      reject_reg      <= reject_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    col_next    = col_reg;
    valid_next  = valid_reg;
    count_next  = count_reg;
    accept_next = 1'b0;
    reject_next = 1'b0;
    case (state_reg)
      OPEN: begin
        if (key_event) begin
          if (bus.key_opcode == CLEAR_CODE) begin
            op_next     = '0;
            col_next    = '0;
            valid_next  = '0;
            count_next  = '0;
            accept_next = 1'b1;
          end else if (bus.key_opcode == SPIN_CODE) begin
            if (count_reg != '0) begin
              state_next  = SPIN;
              accept_next = 1'b1;
            end else begin
              reject_next = 1'b1;
            end
          end else if (bus.chip_color == CHIP_W'(NO_CHIP)) begin
            reject_next = 1'b1;
          end else if (|match_vec) begin
            col_next[hit_idx] = bus.chip_color;
            accept_next       = 1'b1;
          end else if (any_free) begin
            op_next[free_idx]    = bus.key_opcode;
            col_next[free_idx]   = bus.chip_color;
            valid_next[free_idx] = 1'b1;
            count_next           = count_reg + CNT_W'(1);
            accept_next          = 1'b1;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      SPIN: begin
        if (bus.spin_ack) state_next = PAYOUT;
        reject_next = key_event;
      end
      PAYOUT: begin
        // Slots stay frozen until the processor signals it has consumed them.
        if (bus.payout_done) begin
          op_next    = '0;
          col_next   = '0;
          valid_next = '0;
          count_next = '0;
          state_next = OPEN;
        end
        reject_next = key_event;
      end
      default: state_next = OPEN;
    endcase
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_flat
    assign bus.bets_flat[gi*ENTRY_W +: ENTRY_W] =
      valid_reg[gi] ? {col_reg[gi], op_reg[gi]} : {ENTRY_W{1'b0}};
  end

  assign bus.valid_mask   = valid_reg;
  assign bus.bet_count    = count_reg;
  assign bus.full         = (count_reg == CNT_W'(NUM_SLOTS));
  assign bus.spin_req     = (state_reg == SPIN);
  assign bus.locked       = (state_reg == SPIN) || (state_reg == PAYOUT);
  assign bus.accept_pulse = accept_reg;
  assign bus.reject_pulse = reject_reg;

endmodule

// File: tb/tb_bet_ledger.sv
// Directed bench for bet_ledger: keystroke edge detect, merge, full, round
// sequence, simultaneous events, clear and asynchronous reset.
module tb_bet_ledger;
  localparam int NS = 12;
  localparam int OW = 6;
  localparam int CW = 3;
  localparam int EW = OW + CW;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;
  int   acc_cnt;
  int   rej_cnt;
  int   a0, r0;
  logic [NS*EW-1:0] exp_flat;
  logic [NS*EW-1:0] saved_flat;

  bet_ledger_if #(.NUM_SLOTS(NS), .OPCODE_W(OW), .CHIP_W(CW)) bus ();

  bet_ledger #(.NUM_SLOTS(NS), .OPCODE_W(OW), .CHIP_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.accept_pulse) acc_cnt++;
    if (bus.reject_pulse) rej_cnt++;
    if (reset && bus.accept_pulse && bus.reject_pulse) begin
      n_vec++;
      n_miss++;
      $display("FAIL pulse_excl: accept and reject both high, required exclusive");
    end
  end

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe held for 'hold' cycles, then released; pulses are counted by the
  // negedge monitor before the task returns.
  task automatic press(input logic [OW-1:0] op, input logic [CW-1:0] col, input int hold);
    a0 = acc_cnt;
    r0 = rej_cnt;
    @(negedge clock);
    bus.key_strobe = 1'b1;
    bus.key_opcode = op;
    bus.chip_color = col;
    repeat (hold) @(negedge clock);
    bus.key_strobe = 1'b0;
    @(negedge clock);
    $display("key op=%0d col=%0d hold=%0d -> accepts=%0d rejects=%0d count=%0d",
             op, col, hold, acc_cnt - a0, rej_cnt - r0, bus.bet_count);
  endtask

  function automatic logic [EW-1:0] entry(input logic [CW-1:0] col, input logic [OW-1:0] op);
    return {col, op};
  endfunction

  initial begin
    n_vec = 0; n_miss = 0; acc_cnt = 0; rej_cnt = 0;
    bus.key_strobe = 1'b0; bus.key_opcode = '0; bus.chip_color = '0;
    bus.spin_ack = 1'b0; bus.payout_done = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_vec("rst_flat", 128'(bus.bets_flat), 128'd0);
    check_vec("rst_mask", 128'(bus.valid_mask), 128'd0);
    check_vec("rst_count", 128'(bus.bet_count), 128'd0);
    check_vec("rst_lock", 128'({bus.full, bus.spin_req, bus.locked}), 128'd0);
    check_vec("rst_pulse", 128'({bus.accept_pulse, bus.reject_pulse}), 128'd0);
    reset = 1'b1;
    @(negedge clock);

    // Held strobe counts once.
    press(6'd3, 3'b001, 5);
    check_vec("hold_acc", 128'(acc_cnt - a0), 128'd1);
    check_vec("hold_rej", 128'(rej_cnt - r0), 128'd0);
    check_vec("slot0", 128'(bus.bets_flat[8:0]), 128'(9'b001_000011));
    check_vec("count1", 128'(bus.bet_count), 128'd1);

    // Repeat opcode merges into slot 0.
    press(6'd3, 3'b010, 1);
    check_vec("merge_acc", 128'(acc_cnt - a0), 128'd1);
    check_vec("merge_slot0", 128'(bus.bets_flat[8:0]), 128'(9'b010_000011));
    check_vec("merge_count", 128'(bus.bet_count), 128'd1);
    check_vec("merge_slot1", 128'(bus.bets_flat[17:9]), 128'd0);

    // Fill the remaining 11 slots with opcodes 10..20.
    exp_flat = '0;
    exp_flat[0 +: EW] = entry(3'b010, 6'd3);
    for (int k = 1; k < NS; k++) begin
      press(OW'(9 + k), CW'((k % 7) + 1), 1);
      exp_flat[k*EW +: EW] = entry(CW'((k % 7) + 1), OW'(9 + k));
    end
    check_vec("full_flag", 128'(bus.full), 128'd1);
    check_vec("full_mask", 128'(bus.valid_mask), 128'hfff);
    check_vec("full_flat", 128'(bus.bets_flat), 128'(exp_flat));
    saved_flat = bus.bets_flat;
    press(6'd40, 3'b001, 1);
    check_vec("full_rej", 128'(rej_cnt - r0), 128'd1);
    check_vec("full_noacc", 128'(acc_cnt - a0), 128'd0);
    check_vec("full_hold", 128'(bus.bets_flat), 128'(exp_flat));
    check_vec("full_count", 128'(bus.bet_count), 128'd12);

    // Clear from full.
    press(6'b111111, 3'b000, 1);
    check_vec("clr_acc", 128'(acc_cnt - a0), 128'd1);
    check_vec("clr_flat", 128'(bus.bets_flat), 128'd0);
    check_vec("clr_count", 128'(bus.bet_count), 128'd0);

    // No chip present is rejected.
    press(6'd7, 3'b000, 1);
    check_vec("nochip_rej", 128'(rej_cnt - r0), 128'd1);
    check_vec("nochip_mask", 128'(bus.valid_mask), 128'd0);

    // Spin with nothing on the table.
    press(6'b111110, 3'b001, 1);
    check_vec("spin0_rej", 128'(rej_cnt - r0), 128'd1);
    check_vec("spin0_req", 128'(bus.spin_req), 128'd0);

    press(6'd5, 3'b100, 1);
    press(6'b111110, 3'b001, 1);
    check_vec("spin_acc", 128'(acc_cnt - a0), 128'd1);
    check_vec("spin_req_lock", 128'({bus.spin_req, bus.locked}), 128'b11);
    press(6'd9, 3'b001, 1);
    check_vec("spin_keyrej", 128'(rej_cnt - r0), 128'd1);
    check_vec("spin_slot0", 128'(bus.bets_flat[8:0]), 128'(9'b100_000101));
    check_vec("spin_count", 128'(bus.bet_count), 128'd1);

    @(negedge clock);
    bus.spin_ack = 1'b1;
    @(negedge clock);
    bus.spin_ack = 1'b0;
    $display("spin_ack -> spin_req=%0d locked=%0d", bus.spin_req, bus.locked);
    check_vec("payout_state", 128'({bus.spin_req, bus.locked}), 128'b01);
    check_vec("payout_slot0", 128'(bus.bets_flat[8:0]), 128'(9'b100_000101));

    // payout_done and keystroke on the same edge: clear wins, key rejected.
    a0 = acc_cnt; r0 = rej_cnt;
    bus.payout_done = 1'b1;
    bus.key_strobe = 1'b1; bus.key_opcode = 6'd8; bus.chip_color = 3'b001;
    @(negedge clock);
    bus.payout_done = 1'b0;
    bus.key_strobe = 1'b0;
    @(negedge clock);
    $display("payout_done+key -> accepts=%0d rejects=%0d count=%0d",
             acc_cnt - a0, rej_cnt - r0, bus.bet_count);
    check_vec("pd_rej", 128'(rej_cnt - r0), 128'd1);
    check_vec("pd_noacc", 128'(acc_cnt - a0), 128'd0);
    check_vec("pd_flat", 128'(bus.bets_flat), 128'd0);
    check_vec("pd_count", 128'(bus.bet_count), 128'd0);
    check_vec("pd_open", 128'({bus.spin_req, bus.locked}), 128'd0);

    // Four bets then clear.
    for (int k = 0; k < 4; k++) press(OW'(20 + k), 3'b011, 1);
    check_vec("four_mask", 128'(bus.valid_mask), 128'h00f);
    check_vec("four_count", 128'(bus.bet_count), 128'd4);
    press(6'b111111, 3'b000, 1);
    check_vec("clr4_flat", 128'(bus.bets_flat), 128'd0);
    check_vec("clr4_mask", 128'(bus.valid_mask), 128'd0);

    // Asynchronous reset in the middle of SPIN.
    press(6'd1, 3'b111, 1);
    press(6'b111110, 3'b001, 1);
    check_vec("pre_rst_spin", 128'(bus.spin_req), 128'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    $display("async reset mid-spin -> spin_req=%0d locked=%0d count=%0d",
             bus.spin_req, bus.locked, bus.bet_count);
    check_vec("arst_spin", 128'({bus.spin_req, bus.locked}), 128'd0);
    check_vec("arst_count", 128'(bus.bet_count), 128'd0);
    check_vec("arst_flat", 128'(bus.bets_flat), 128'd0);
    @(negedge clock);
    reset = 1'b1;
    press(6'd2, 3'b001, 1);
    check_vec("post_rst_acc", 128'(acc_cnt - a0), 128'd1);
    check_vec("post_rst_count", 128'(bus.bet_count), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bet_ledger.md
Name: bet_ledger

Overview:
- Parametrised successor to the fixed 12-register bet latch in the roulette top level.
- Records keyboard bets into NUM_SLOTS slots. Each slot holds {chip_color, bet_opcode}.
- Detects each keystroke once, via a rising edge on key_strobe; this removes the old double-count-by-2 scheme.
- Merges repeat bets on the same opcode, runs the OPEN/SPIN/PAYOUT round sequence, and presents a flattened slot bus to the regfile payout logic.

Parameters:
NUM_SLOTS, 12, number of bet slots
OPCODE_W, 6, bet opcode width from keyboardToBet
CHIP_W, 3, Arduino chip-colour width; value 0 means no chip present
SPIN_CODE, 6'b111110, opcode that requests a spin
CLEAR_CODE, 6'b111111, opcode that clears all bets
(derived) ENTRY_W = CHIP_W+OPCODE_W; CNT_W = $clog2(NUM_SLOTS+1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_strobe  in  1  level from Ps2Controller read_data; may stay high for several cycles
key_opcode  in  OPCODE_W  decoded bet opcode; valid while key_strobe is high
chip_color  in  CHIP_W  Arduino colour sensor (JB[2:0])
spin_ack  in  1  wheel/servo controller has finished the spin
payout_done  in  1  processor has consumed the bets and finalpayout is valid
bets_flat  out  NUM_SLOTS*ENTRY_W  slot k is at [k*ENTRY_W +: ENTRY_W]; an empty slot reads 0
valid_mask  out  NUM_SLOTS  bit k is set when slot k is occupied
bet_count  out  CNT_W  number of occupied slots
full  out  1  bet_count == NUM_SLOTS
spin_req  out  1  high throughout SPIN
locked  out  1  high in SPIN and PAYOUT
accept_pulse  out  1  one-cycle pulse when a keystroke is accepted
reject_pulse  out  1  one-cycle pulse when a keystroke is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - All slots, valid_mask and bet_count go to 0; state goes to OPEN.
  - spin_req, locked, accept_pulse and reject_pulse go to 0.
  - The edge-detect register is cleared to 0.
- Keystroke event:
  - A keystroke is key_strobe=1 this cycle with key_strobe=0 on the previous cycle, one registered flop.
  - A strobe held high counts as exactly one event.
  - Results are visible one clock after the sampling edge, together with the corresponding pulse.
- State OPEN:
  - Opcode == CLEAR_CODE: clear all slots and set count to 0; accept_pulse.
  - Opcode == SPIN_CODE with bet_count > 0: go to SPIN; accept_pulse.
  - Opcode == SPIN_CODE with bet_count == 0: reject_pulse; stay in OPEN.
  - Bet opcode with chip_color == 0: reject_pulse; no change.
  - Bet opcode that matches a valid slot's opcode: overwrite that slot's colour field; count unchanged; accept_pulse.
  - New bet opcode with !full: write the lowest-index empty slot; count+1; accept_pulse.
  - New bet opcode with full: reject_pulse; no change.
- State SPIN:
  - spin_req=1 and locked=1.
  - On spin_ack=1, go to PAYOUT.
  - Every keystroke is rejected.
- State PAYOUT:
  - locked=1; slots are held stable for the processor.
  - On payout_done=1: clear all slots and set count to 0 at that edge; go to OPEN.
  - Every keystroke is rejected.
- Ignored inputs: spin_ack outside SPIN and payout_done outside PAYOUT are ignored.
- Simultaneous events:
  - Keystroke plus payout_done in PAYOUT: the clear wins and the key is rejected.
  - Keystroke plus spin_ack in SPIN: the transition happens and the key is rejected.
- Exclusivity: accept_pulse and reject_pulse are never high in the same cycle.
- Invariants: bet_count always equals popcount(valid_mask). Slots never hold duplicate opcodes.
- Reset mid-round: an abandoned spin or payout returns to OPEN with everything empty; no pulses are emitted.

Decomposition:
- roulette_pkg holds:
  - SPIN_CODE and CLEAR_CODE defaults, NO_CHIP=0;
  - the state enum {OPEN, SPIN, PAYOUT};
  - the ENTRY_W helper function.
- Sub-module bet_slot_lookup (combinational, parametrised by NUM_SLOTS and OPCODE_W) produces:
  - the per-slot opcode match vector and hit index;
  - the first-free priority-encoded index and any_free flag.
- The sequential logic, state machine and edge detect stay in bet_ledger.

Test Plan:
- Reset, then key_strobe high for 5 cycles with opcode 6'd3 and colour 3'b001 -> exactly one accept_pulse; slot0 = 9'b001_000011; bet_count=1.
- Opcode 3 again with colour 3'b010 -> slot0 colour becomes 010; bet_count stays 1; slot1 stays 0.
- 12 distinct bet opcodes, then a 13th -> full=1 after the 12th; 13th gives reject_pulse; bets_flat unchanged.
- SPIN_CODE with count 0 -> reject_pulse; after one bet, SPIN_CODE -> spin_req=1 and locked=1; a bet key during SPIN -> reject_pulse; spin_ack -> PAYOUT with slots intact.
- In PAYOUT, payout_done and a keystroke in the same cycle -> slots cleared, count=0, reject_pulse, state OPEN.
- CLEAR_CODE with 4 bets in OPEN -> all slots 0, valid_mask=0; reset asserted mid-SPIN -> spin_req=0 and state OPEN immediately (asynchronous).
